// File: rtl/tick_sched.sv
// tick_sched: programmable prescaler tick shared by NCH countdown timers.
// Ports: clk, rst (async, active-low), wr_*/rd_* register bus, tick_out, irq.
module tick_sched #(
  parameter int NCH          = 4,
  parameter int CW           = 16,
  parameter int PW           = 17,
  parameter int DEF_PRESCALE = 99999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        tick_out,
  output logic        irq
);

  localparam logic [3:0] A_PRE = 4'h0;
  localparam logic [3:0] A_GLB = 4'h1;
  localparam logic [3:0] A_PND = 4'h2;
  localparam logic [3:0] A_MSK = 4'h3;

  logic [PW-1:0]  prescale;
  logic [PW-1:0]  pcnt;
  logic           gen;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] mask;
  logic [NCH-1:0] cen;
  logic [NCH-1:0] cper;
  logic [CW-1:0]  period [NCH];
  logic [CW-1:0]  count  [NCH];

  logic           wr_pre;
  logic           wr_glb;
  logic           wr_pnd;
  logic           wr_msk;
  logic [NCH-1:0] wr_cfg;
  logic [NCH-1:0] expire;
  logic [NCH-1:0] clr;
  logic           unused_bits;

  assign unused_bits = ^wr_data;

  assign wr_pre = wr_en && (wr_addr == A_PRE);
  assign wr_glb = wr_en && (wr_addr == A_GLB);
  assign wr_pnd = wr_en && (wr_addr == A_PND);
  assign wr_msk = wr_en && (wr_addr == A_MSK);
  assign clr    = wr_pnd ? wr_data[NCH-1:0] : '0;

  // A CFG write overrides tick processing in the same cycle.
  always_comb begin
    wr_cfg = '0;
    expire = '0;
    for (int c = 0; c < NCH; c++) begin
      wr_cfg[c] = wr_en && (wr_addr == 4'(8 + c));
      expire[c] = tick_out && cen[c] && !wr_cfg[c]
                  && (count[c] == '0);
    end
  end

  // Prescaler: any PRESCALE/GLOBAL write restarts the period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale <= PW'(DEF_PRESCALE);
      gen      <= 1'b0;
      pcnt     <= '0;
      tick_out <= 1'b0;
    end else begin
      if (wr_pre) prescale <= wr_data[PW-1:0];
      if (wr_glb) gen <= wr_data[0];
      if (wr_pre || wr_glb) begin
        pcnt     <= '0;
        tick_out <= 1'b0;
      end else if (!gen) begin
        pcnt     <= '0;
        tick_out <= 1'b0;
      end else if (pcnt == prescale) begin
        pcnt     <= '0;
        tick_out <= 1'b1;
      end else begin
        pcnt     <= pcnt + PW'(1);
        tick_out <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cen  <= '0;
      cper <= '0;
      for (int c = 0; c < NCH; c++) begin
        period[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (wr_cfg[c]) begin
          period[c] <= wr_data[CW-1:0];
          count[c]  <= wr_data[CW-1:0];
          cen[c]    <= wr_data[16];
          cper[c]   <= wr_data[17];
        end else if (tick_out && cen[c]) begin
          if (count[c] == '0) begin
            if (cper[c]) count[c] <= period[c];
            else         cen[c]   <= 1'b0;
          end else begin
            count[c] <= count[c] - CW'(1);
          end
        end
      end
    end
  end

  // New expiries win over a simultaneous W1C.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      mask    <= '0;
      irq     <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | expire;
      if (wr_msk) mask <= wr_data[NCH-1:0];
      irq <= |(pending & mask);
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr[3:2])
      2'b00: begin
        case (rd_addr[1:0])
          2'd0:    rd_data[PW-1:0]  = prescale;
          2'd1:    rd_data[0]       = gen;
          2'd2:    rd_data[NCH-1:0] = pending;
          default: rd_data[NCH-1:0] = mask;
        endcase
      end
      2'b10: begin
        for (int c = 0; c < NCH; c++) begin
          if (rd_addr[1:0] == 2'(c)) begin
            rd_data[CW-1:0] = period[c];
            rd_data[16]     = cen[c];
            rd_data[17]     = cper[c];
          end
        end
      end
      2'b11: begin
        for (int c = 0; c < NCH; c++) begin
          if (rd_addr[1:0] == 2'(c)) rd_data[CW-1:0] = count[c];
        end
      end
      default: rd_data = '0;
    endcase
  end

endmodule
